// File: rtl/vco_fc_pkg.sv
// Shared types and defaults for the multi-channel VCO frequency counter.
//   fc_state_t    : measurement FSM states (IDLE, GATE)
//   DEF_*         : default channel count, count width and gate width
//   sr_width()    : width of the serial readout register
package vco_fc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } fc_state_t;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_GATE_W   = 20;

    function automatic int sr_width(input int channels, input int cnt_w);
        return channels * cnt_w;
    endfunction

endpackage

// File: rtl/vco_freq_counter_array_if.sv
// Control/result bundle of the VCO frequency counter array.
//   master : the controller side (drives start/config/readout, sees results)
//   slave  : the counter itself
// Signals: ch_en_i, gate_len_i, start_i, continuous_i, abort_i, rd_load_i,
//          shift_i (controls); sr_out_o, result_o, ovf_o, busy_o, done_o.
interface vco_freq_counter_array_if
    import vco_fc_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int GATE_W   = DEF_GATE_W
);
    logic [CHANNELS-1:0]       ch_en_i;
    logic [GATE_W-1:0]         gate_len_i;
    logic                      start_i;
    logic                      continuous_i;
    logic                      abort_i;
    logic                      rd_load_i;
    logic                      shift_i;
    logic                      sr_out_o;
    logic [CHANNELS*CNT_W-1:0] result_o;
    logic [CHANNELS-1:0]       ovf_o;
    logic                      busy_o;
    logic                      done_o;

    modport master (
        output ch_en_i, gate_len_i, start_i, continuous_i, abort_i, rd_load_i, shift_i,
        input  sr_out_o, result_o, ovf_o, busy_o, done_o
    );

    modport slave (
        input  ch_en_i, gate_len_i, start_i, continuous_i, abort_i, rd_load_i, shift_i,
        output sr_out_o, result_o, ovf_o, busy_o, done_o
    );

endinterface

// File: rtl/vco_fc_sync_edge.sv
// One channel's input conditioning: two-flop synchroniser for the
// asynchronous VCO output followed by a rising-edge detector.
//   wb_clk_i, wb_rst_i : clock, async active-high reset
//   sens_i             : raw VCO output
//   edge_o             : one-cycle pulse per synchronised rising edge
module vco_fc_sync_edge (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic sens_i,
    output logic edge_o
);
    logic s1, s2, s3;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sens_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_o = s2 & ~s3;

endmodule

// File: rtl/vco_freq_counter_array.sv
// Multi-channel gated frequency counter for the VCO outputs.
// Counts synchronised rising edges of each enabled channel over a
// programmable window of wb_clk_i cycles (one-shot or continuous), latches
// the saturating counts and overflow flags, and offers them in parallel and
// through a serial shift-out register (highest channel MSB first).
//   wb_clk_i, wb_rst_i : clock, async active-high reset
//   sens_i             : VCO outputs, asynchronous to wb_clk_i
//   bus (slave)        : control inputs and result/status outputs
module vco_freq_counter_array
    import vco_fc_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int GATE_W   = DEF_GATE_W
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [CHANNELS-1:0]     sens_i,
    vco_freq_counter_array_if.slave bus
);
    localparam int               SR_W    = sr_width(CHANNELS, CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        if (inc && (cnt != CNT_MAX)) return cnt + 1'b1;
        return cnt;
    endfunction

    fc_state_t           state, state_nxt;
    logic [GATE_W-1:0]   gate_cnt, gate_len_q;
    logic [CHANNELS-1:0] en_q, edge_det, ovf_q, ovf_nxt;
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_nxt [CHANNELS];
    logic [SR_W-1:0]     result_q, sr_q;
    logic                done_q, win_end, do_start, do_update;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        vco_fc_sync_edge u_sync (
            .wb_clk_i (wb_clk_i),
            .wb_rst_i (wb_rst_i),
            .sens_i   (sens_i[c]),
            .edge_o   (edge_det[c])
        );
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_update = 1'b0;
        win_end   = (gate_cnt == GATE_W'(1));
        case (state)
            IDLE: begin
                if (bus.start_i && (bus.gate_len_i != '0)) begin
                    state_nxt = GATE;
                    do_start  = 1'b1;
                end
            end
            GATE: begin
                // Abort wins over a coinciding end of window.
                if (bus.abort_i) begin
                    state_nxt = IDLE;
                end else if (win_end) begin
                    do_update = 1'b1;
                    state_nxt = bus.continuous_i ? GATE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // The next count includes this cycle's edge, so the final cycle of a
        // window is captured into the result. Counts only ever grow within a
        // window, so "at max" is the sticky overflow condition.
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_nxt[c] = (state == GATE && en_q[c]) ? sat_inc(cnt_q[c], edge_det[c]) : cnt_q[c];
            ovf_nxt[c] = (cnt_nxt[c] == CNT_MAX);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            gate_cnt   <= '0;
            gate_len_q <= '0;
            en_q       <= '0;
            for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
        end else if (do_start) begin
            gate_cnt   <= bus.gate_len_i;
            gate_len_q <= bus.gate_len_i;
            en_q       <= bus.ch_en_i;
            for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
        end else if (state == GATE) begin
            if (win_end) begin
                // Re-arm immediately so continuous mode has no dead cycle.
                gate_cnt <= gate_len_q;
                for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
            end else begin
                gate_cnt <= gate_cnt - 1'b1;
                for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_nxt[c];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            result_q <= '0;
            ovf_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= do_update;
            if (do_update) begin
                ovf_q <= ovf_nxt;
                for (int c = 0; c < CHANNELS; c++) result_q[c*CNT_W +: CNT_W] <= cnt_nxt[c];
            end
        end
    end

    // Readout register is independent of result updates; load beats shift.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)           sr_q <= '0;
        else if (bus.rd_load_i) sr_q <= result_q;
        else if (bus.shift_i)   sr_q <= {sr_q[SR_W-2:0], 1'b0};
    end

    assign bus.sr_out_o = sr_q[SR_W-1];
    assign bus.result_o = result_q;
    assign bus.ovf_o    = ovf_q;
    assign bus.busy_o   = (state == GATE);
    assign bus.done_o   = done_q;

endmodule

// File: tb/tb_vco_freq_counter_array.sv
module tb_vco_freq_counter_array;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] sens = '0;
    int             per [NCH];
    int             ph  [NCH];
    logic [NCH-1:0] prev = '0;
    int             rise_q [NCH][$];
    int             cyc = 0;
    int             total = 0;
    int             bad = 0;
    logic [63:0]    last_exp = '0;

    vco_freq_counter_array_if #(.CHANNELS(4), .CNT_W(16), .GATE_W(20)) bus ();
    vco_freq_counter_array_if #(.CHANNELS(2), .CNT_W(8),  .GATE_W(20)) bus2 ();

    vco_freq_counter_array #(.CHANNELS(4), .CNT_W(16), .GATE_W(20)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .sens_i   (sens),
        .bus      (bus)
    );

    vco_freq_counter_array #(.CHANNELS(2), .CNT_W(8), .GATE_W(20)) u_sat (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .sens_i   (sens[1:0]),
        .bus      (bus2)
    );

    always #5 clk = ~clk;

    // Square-wave VCO stand-ins, changing on the falling clock edge.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (per[c] == 0) begin
                ph[c]   = 0;
                sens[c] = 1'b0;
            end else begin
                ph[c]   = (ph[c] + 1 >= per[c]) ? 0 : ph[c] + 1;
                sens[c] = (ph[c] < per[c] / 2);
            end
        end
    end

    // Reference: log the rising-edge index (in rising clock edges) of each input.
    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (rst) prev[c] = 1'b0;
            else begin
                if (sens[c] && !prev[c]) rise_q[c].push_back(cyc);
                prev[c] = sens[c];
            end
        end
        cyc++;
    end

    // A rise seen at clock edge j is counted at edge j+2; a window armed at
    // edge k counts at edges k+1 .. k+len.
    function automatic int window_rises(input int c, input int k, input int len);
        int n = 0;
        for (int i = 0; i < rise_q[c].size(); i++)
            if (rise_q[c][i] >= k - 1 && rise_q[c][i] <= k + len - 2) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0][7:0]  per;
        logic [3:0]       en;
        logic [15:0]      len;
        logic             cont;
        logic [3:0]       nwin;
        logic [3:0][15:0] nom;
    } vec_t;

    vec_t vecs [4];

    task automatic set_per(input logic [3:0][7:0] p);
        for (int c = 0; c < NCH; c++) per[c] = int'(p[c]);
        repeat (10) @(negedge clk);
    endtask

    task automatic run_meas(input logic [3:0] en, input int len, input int nwin,
                            input logic [3:0][15:0] nom, input bit use_nom, input string tag);
        int k;
        @(negedge clk);
        bus.ch_en_i      = en;
        bus.gate_len_i   = 20'(len);
        bus.continuous_i = (nwin > 1);
        bus.start_i      = 1'b1;
        k = cyc;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int w = 0; w < nwin; w++) begin
            int kw, busy_n, done_n;
            logic [63:0] exp_word;
            logic [3:0]  exp_ovf;
            kw = k + w * len;
            busy_n = 0;
            done_n = 0;
            if (w == nwin - 1) bus.continuous_i = 1'b0;
            for (int i = 0; i < len; i++) begin
                if (bus.busy_o) busy_n++;
                if (bus.done_o && !(i == 0 && w > 0)) done_n++;
                @(negedge clk);
            end
            chk($sformatf("%s w%0d busy cycles", tag, w), 64'(busy_n), 64'(len));
            chk($sformatf("%s w%0d early done", tag, w), 64'(done_n), 64'd0);
            chk($sformatf("%s w%0d done pulse", tag, w), 64'(bus.done_o), 64'd1);
            exp_word = '0;
            exp_ovf  = '0;
            for (int c = 0; c < NCH; c++) begin
                int n, act;
                n = en[c] ? window_rises(c, kw, len) : 0;
                if (n >= 65535) begin n = 65535; exp_ovf[c] = 1'b1; end
                exp_word[c*16 +: 16] = 16'(n);
                act = int'(bus.result_o[c*16 +: 16]);
                chk($sformatf("%s w%0d ch%0d count", tag, w, c), 64'(act), 64'(n));
                if (use_nom)
                    chk($sformatf("%s w%0d ch%0d nominal %0d+-1 (got %0d)", tag, w, c, nom[c], act),
                        64'((act >= int'(nom[c]) - 1) && (act <= int'(nom[c]) + 1)), 64'd1);
            end
            chk($sformatf("%s w%0d ovf", tag, w), 64'(bus.ovf_o), 64'(exp_ovf));
            last_exp = exp_word;
        end
        chk({tag, " idle after last window"}, 64'(bus.busy_o), 64'd0);
    endtask

    task automatic read_stream(output logic [63:0] s, output int dn);
        s  = '0;
        dn = 0;
        bus.shift_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            s = {s[62:0], bus.sr_out_o};
            if (bus.done_o) dn++;
            @(negedge clk);
        end
        bus.shift_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the test sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, done_n, n;
        logic [63:0] s, exp_word;

        bus.ch_en_i = '0;  bus.gate_len_i = '0;  bus.start_i = 1'b0;  bus.continuous_i = 1'b0;
        bus.abort_i = 1'b0; bus.rd_load_i = 1'b0; bus.shift_i = 1'b0;
        bus2.ch_en_i = '0; bus2.gate_len_i = '0; bus2.start_i = 1'b0; bus2.continuous_i = 1'b0;
        bus2.abort_i = 1'b0; bus2.rd_load_i = 1'b0; bus2.shift_i = 1'b0;

        //                 per {ch3,ch2,ch1,ch0}         en       len   cont nwin nom {ch3,ch2,ch1,ch0}
        vecs[0] = '{per: {8'd0, 8'd0, 8'd0, 8'd10},   en: 4'b1111, len: 16'd1000, cont: 1'b0, nwin: 4'd1,
                    nom: {16'd0, 16'd0, 16'd0, 16'd100}};
        vecs[1] = '{per: {8'd20, 8'd20, 8'd8, 8'd10}, en: 4'b0101, len: 16'd500,  cont: 1'b1, nwin: 4'd3,
                    nom: {16'd0, 16'd25, 16'd0, 16'd50}};
        vecs[2] = '{per: {8'd12, 8'd6, 8'd4, 8'd0},   en: 4'b1110, len: 16'd240,  cont: 1'b0, nwin: 4'd1,
                    nom: {16'd20, 16'd40, 16'd60, 16'd0}};
        vecs[3] = '{per: {8'd0, 8'd0, 8'd0, 8'd10},   en: 4'b0001, len: 16'd770,  cont: 1'b0, nwin: 4'd1,
                    nom: {16'd0, 16'd0, 16'd0, 16'd77}};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset result", bus.result_o, 64'd0);
        chk("reset ovf", 64'(bus.ovf_o), 64'd0);
        chk("reset busy", 64'(bus.busy_o), 64'd0);
        chk("reset done", 64'(bus.done_o), 64'd0);
        chk("reset sr_out", 64'(bus.sr_out_o), 64'd0);

        // Randomised windows against the edge-log reference.
        for (int r = 0; r < 5; r++) begin
            logic [3:0][7:0] p;
            for (int c = 0; c < NCH; c++)
                p[c] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(4, 30));
            set_per(p);
            run_meas(4'($urandom), int'($urandom_range(40, 400)), int'($urandom_range(1, 2)),
                     '0, 1'b0, $sformatf("rand%0d", r));
        end

        // Readout: stream of the last result, with a short window finishing mid-shift.
        set_per({8'd6, 8'd6, 8'd6, 8'd6});
        exp_word = last_exp;
        @(negedge clk);
        bus.rd_load_i = 1'b1;
        bus.ch_en_i = 4'b1111; bus.gate_len_i = 20'd20; bus.continuous_i = 1'b0; bus.start_i = 1'b1;
        k = cyc;
        @(negedge clk);
        bus.rd_load_i = 1'b0;
        bus.start_i = 1'b0;
        read_stream(s, done_n);
        chk("readout stream", s, exp_word);
        chk("readout done during shift", 64'(done_n), 64'd1);
        chk("readout zero fill", 64'(bus.sr_out_o), 64'd0);
        exp_word = '0;
        for (int c = 0; c < NCH; c++) exp_word[c*16 +: 16] = 16'(window_rises(c, k, 20));
        chk("readout new result", bus.result_o, exp_word);
        last_exp = exp_word;

        // Load and shift together: load must win.
        @(negedge clk);
        bus.rd_load_i = 1'b1;
        bus.shift_i = 1'b1;
        @(negedge clk);
        bus.rd_load_i = 1'b0;
        read_stream(s, done_n);
        chk("load beats shift stream", s, last_exp);

        // Table vectors from the test plan.
        for (int v = 0; v < 4; v++) begin
            set_per(vecs[v].per);
            run_meas(vecs[v].en, int'(vecs[v].len), vecs[v].cont ? int'(vecs[v].nwin) : 1,
                     vecs[v].nom, 1'b1, $sformatf("vec%0d", v));
        end

        // Abort at cycle 300 of a 1000-cycle window after a result of 77.
        @(negedge clk);
        bus.ch_en_i = 4'b0001; bus.gate_len_i = 20'd1000; bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        done_n = 0;
        repeat (299) begin
            if (bus.done_o) done_n++;
            @(negedge clk);
        end
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("abort idle next cycle", 64'(bus.busy_o), 64'd0);
        repeat (20) begin
            if (bus.done_o) done_n++;
            @(negedge clk);
        end
        chk("abort no done", 64'(done_n), 64'd0);
        chk("abort result ch0 kept", 64'(bus.result_o[15:0]), 64'd77);
        chk("abort result kept", bus.result_o, last_exp);

        // Abort in the final cycle of a window beats the end of window.
        @(negedge clk);
        bus.gate_len_i = 20'd50; bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (49) @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("late abort idle", 64'(bus.busy_o), 64'd0);
        chk("late abort no done", 64'(bus.done_o), 64'd0);
        @(negedge clk);
        chk("late abort no done later", 64'(bus.done_o), 64'd0);
        chk("late abort result kept", bus.result_o, last_exp);

        // Zero-length start is ignored.
        bus.gate_len_i = 20'd0;
        bus.start_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("zero length start ignored %0d", i), 64'({bus.busy_o, bus.done_o}), 64'd0);
        end
        bus.start_i = 1'b0;

        // Saturation on the 8-bit instance.
        set_per({8'd0, 8'd0, 8'd4, 8'd0});
        @(negedge clk);
        bus2.ch_en_i = 2'b11; bus2.gate_len_i = 20'd2000; bus2.start_i = 1'b1;
        k = cyc;
        @(negedge clk);
        bus2.start_i = 1'b0;
        repeat (2000) @(negedge clk);
        n = window_rises(1, k, 2000);
        chk("sat done", 64'(bus2.done_o), 64'd1);
        chk("sat ch1 count", 64'(bus2.result_o[15:8]), 64'((n >= 255) ? 255 : n));
        chk("sat ch1 at max", 64'(bus2.result_o[15:8]), 64'd255);
        chk("sat ch1 ovf", 64'(bus2.ovf_o[1]), 64'd1);
        chk("sat ch0 idle", 64'({bus2.ovf_o[0], bus2.result_o[7:0]}), 64'd0);

        // Asynchronous reset in the middle of a window.
        set_per({8'd10, 8'd10, 8'd10, 8'd10});
        @(negedge clk);
        bus.ch_en_i = 4'b1111; bus.gate_len_i = 20'd1000; bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.rd_load_i = 1'b1;
        @(negedge clk);
        bus.rd_load_i = 1'b0;
        for (int i = 0; i < 64 && !bus.sr_out_o; i++) begin
            bus.shift_i = 1'b1;
            @(negedge clk);
        end
        bus.shift_i = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async reset result", bus.result_o, 64'd0);
        chk("async reset ovf", 64'(bus.ovf_o), 64'd0);
        chk("async reset busy", 64'(bus.busy_o), 64'd0);
        chk("async reset done", 64'(bus.done_o), 64'd0);
        chk("async reset sr_out", 64'(bus.sr_out_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last_exp = '0;
        set_per(vecs[0].per);
        run_meas(vecs[0].en, int'(vecs[0].len), 1, vecs[0].nom, 1'b1, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
